// File: rtl/riscv_multicycle_control_pkg.sv
// ============================================================================
// riscv_multicycle_control_pkg : opcodes, FSM states, opcode classes and codes
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_multicycle_control_pkg;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_32     = 7'b0111011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_TRAP    = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      CLS_ALU_REG = 4'd0,
      CLS_ALU_IMM = 4'd1,
      CLS_LOAD    = 4'd2,
      CLS_STORE   = 4'd3,
      CLS_BRANCH  = 4'd4,
      CLS_JAL     = 4'd5,
      CLS_JALR    = 4'd6,
      CLS_LUI     = 4'd7,
      CLS_AUIPC   = 4'd8,
      CLS_ILLEGAL = 4'd15
   } op_class_t;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_IMM  = 2'b11;

   localparam logic [1:0] TC_NONE    = 2'b00;
   localparam logic [1:0] TC_ILLEGAL = 2'b01;
   localparam logic [1:0] TC_IMEM    = 2'b10;
   localparam logic [1:0] TC_DMEM    = 2'b11;

   // Classes whose ALU B operand is the immediate rather than rs2.
   function automatic logic class_uses_imm(input op_class_t cls);
      return (cls == CLS_ALU_IMM) || (cls == CLS_LOAD) || (cls == CLS_STORE) ||
             (cls == CLS_JALR) || (cls == CLS_LUI) || (cls == CLS_AUIPC);
   endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_multicycle_control_decoder.sv
// ============================================================================
// riscv_multicycle_control_decoder : combinational RV64I opcode classifier
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_multicycle_control_decoder
   import riscv_multicycle_control_pkg::*;
(
   input  logic [6:0] opcode,
   output op_class_t  op_class,
   output logic       legal,
   output logic       is_mem,
   output logic       is_store,
   output logic       writes_rd
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         OP_OP, OP_32:         op_class = CLS_ALU_REG;
         OP_IMM, OP_IMM_32:    op_class = CLS_ALU_IMM;
         OP_LOAD:              op_class = CLS_LOAD;
         OP_STORE:             op_class = CLS_STORE;
         OP_BRANCH:            op_class = CLS_BRANCH;
         OP_JAL:               op_class = CLS_JAL;
         OP_JALR:              op_class = CLS_JALR;
         OP_LUI:               op_class = CLS_LUI;
         OP_AUIPC:             op_class = CLS_AUIPC;
         default:              op_class = CLS_ILLEGAL;
      endcase
   end

   assign legal     = (op_class != CLS_ILLEGAL);
   assign is_mem    = (op_class == CLS_LOAD) || (op_class == CLS_STORE);
   assign is_store  = (op_class == CLS_STORE);
   assign writes_rd = legal && (op_class != CLS_STORE) && (op_class != CLS_BRANCH);

endmodule

`default_nettype wire

// File: rtl/riscv_multicycle_control.sv
// ============================================================================
// riscv_multicycle_control : multi-cycle RV64I sequencer (FETCH..WB, TRAP)
// Optional counters built when CTRL_PERF_CNT_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module riscv_multicycle_control
   import riscv_multicycle_control_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 64
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic [6:0]       opcode,
   input  logic [2:0]       func,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_load,
   output logic             pc_load,
   output logic             pc_next_sel,
   output logic             pc_adder_sel,
   output logic             alu_src_b,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_t        state, state_nxt;
   logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic          trap_nxt;
   logic [1:0]    trap_cause_nxt;
   logic          tmo_hit;

   op_class_t     op_class;
   logic          legal, is_mem, is_store, writes_rd;

   // func only feeds the PC block's branch compare; it never steers sequencing.
   logic unused_func;
   assign unused_func = ^func;

   riscv_multicycle_control_decoder u_dec (
      .opcode    (opcode),
      .op_class  (op_class),
      .legal     (legal),
      .is_mem    (is_mem),
      .is_store  (is_store),
      .writes_rd (writes_rd)
   );

   // The limit cycle still honours a ready arriving in that same cycle.
   assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_cnt == TW'(MEM_TIMEOUT));

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state      <= ST_FETCH;
         tmo_cnt    <= '0;
         trap       <= 1'b0;
         trap_cause <= TC_NONE;
      end else begin
         state      <= state_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         trap       <= trap_nxt;
         trap_cause <= trap_cause_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      tmo_cnt_nxt    = tmo_cnt;
      trap_nxt       = trap;
      trap_cause_nxt = trap_cause;
      imem_req       = 1'b0;
      dmem_req       = 1'b0;
      dmem_we        = 1'b0;
      ir_load        = 1'b0;
      pc_load        = 1'b0;
      pc_next_sel    = 1'b0;
      pc_adder_sel   = 1'b0;
      alu_src_b      = 1'b0;
      rf_we          = 1'b0;
      wb_sel         = WB_ALU;

      // Outputs stay quiet while reset is asserted so an aborted instruction never retires.
      if (RST) begin
         if (state == ST_EXECUTE || state == ST_MEM || state == ST_WB) begin
            alu_src_b    = class_uses_imm(op_class);
            pc_next_sel  = (op_class == CLS_JAL) || (op_class == CLS_JALR);
            pc_adder_sel = (op_class == CLS_JAL) || (op_class == CLS_BRANCH);
            case (op_class)
               CLS_LOAD:          wb_sel = WB_LOAD;
               CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
               CLS_LUI:           wb_sel = WB_IMM;
               default:           wb_sel = WB_ALU;
            endcase
         end

         case (state)
            ST_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_load   = 1'b1;
                  state_nxt = ST_DECODE;
               end else if (tmo_hit) begin
                  state_nxt      = ST_TRAP;
                  trap_nxt       = 1'b1;
                  trap_cause_nxt = TC_IMEM;
               end else if (MEM_TIMEOUT != 0) begin
                  tmo_cnt_nxt = tmo_cnt + TW'(1);
               end
            end
            ST_DECODE: begin
               if (!legal) begin
                  state_nxt      = ST_TRAP;
                  trap_nxt       = 1'b1;
                  trap_cause_nxt = TC_ILLEGAL;
               end else begin
                  state_nxt = ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               if (is_mem) begin
                  state_nxt   = ST_MEM;
                  tmo_cnt_nxt = '0;
               end else begin
                  state_nxt = ST_WB;
               end
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = is_store;
               if (dmem_ready) begin
                  state_nxt = ST_WB;
               end else if (tmo_hit) begin
                  state_nxt      = ST_TRAP;
                  trap_nxt       = 1'b1;
                  trap_cause_nxt = TC_DMEM;
               end else if (MEM_TIMEOUT != 0) begin
                  tmo_cnt_nxt = tmo_cnt + TW'(1);
               end
            end
            ST_WB: begin
               pc_load     = 1'b1;
               rf_we       = writes_rd;
               state_nxt   = ST_FETCH;
               tmo_cnt_nxt = '0;
            end
            ST_TRAP: begin
               state_nxt = ST_TRAP;
            end
            default: begin
               state_nxt = ST_FETCH;
            end
         endcase
      end
   end

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cyc_q, ret_q;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_q + CNT_W'(1);
         if (pc_load) begin
            ret_q <= ret_q + CNT_W'(1);
         end
      end
   end

   assign cycle_cnt   = cyc_q;
   assign instret_cnt = ret_q;
`else
   assign cycle_cnt   = '0;
   assign instret_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_multicycle_control.sv
// ============================================================================
// tb_riscv_multicycle_control : directed self-checking bench for the sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_riscv_multicycle_control;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [6:0]  opcode = '0;
   logic [2:0]  func = '0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, dmem_req, dmem_we, ir_load, pc_load;
   logic        pc_next_sel, pc_adder_sel, alu_src_b, rf_we, trap;
   logic [1:0]  wb_sel, trap_cause;
   logic [63:0] cycle_cnt, instret_cnt;

   int total = 0;
   int bad   = 0;

   int         res_cycles, res_mem, res_pcl, res_irl;
   logic       res_rf, res_we, res_next, res_adder, res_srcb, res_trap, res_first_req;
   logic [1:0] res_wb;

   always #5 CLK = ~CLK;

   riscv_multicycle_control #(
      .MEM_TIMEOUT (4),
      .CNT_W       (64)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .opcode       (opcode),
      .func         (func),
      .imem_ready   (imem_ready),
      .dmem_ready   (dmem_ready),
      .imem_req     (imem_req),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .ir_load      (ir_load),
      .pc_load      (pc_load),
      .pc_next_sel  (pc_next_sel),
      .pc_adder_sel (pc_adder_sel),
      .alu_src_b    (alu_src_b),
      .rf_we        (rf_we),
      .wb_sel       (wb_sel),
      .trap         (trap),
      .trap_cause   (trap_cause),
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Entered at posedge+1 in FETCH; returns at posedge+1 after WB, or at posedge+2 once trapped.
   task automatic run_instr(input logic [6:0] op, input int dwait);
      logic done;
      res_cycles = 0; res_mem = 0; res_pcl = 0; res_irl = 0;
      res_rf = 0; res_we = 0; res_next = 0; res_adder = 0; res_srcb = 0;
      res_trap = 0; res_first_req = 0; res_wb = 2'b00;
      opcode     = op;
      imem_ready = 1'b1;
      for (int c = 0; c < 30; c++) begin
         dmem_ready = (res_mem >= dwait);
         #1;
         if (trap) begin
            res_trap = 1'b1;
            break;
         end
         if (c == 0) res_first_req = imem_req;
         if (ir_load) res_irl++;
         if (dmem_req) begin
            res_mem++;
            if (dmem_we) res_we = 1'b1;
         end
         if (pc_load) begin
            res_pcl++;
            res_rf    = rf_we;
            res_wb    = wb_sel;
            res_next  = pc_next_sel;
            res_adder = pc_adder_sel;
            res_srcb  = alu_src_b;
         end
         res_cycles++;
         done = pc_load;
         @(posedge CLK);
         #1;
         if (done) break;
      end
      dmem_ready = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b0;
      @(posedge CLK);
      #1;
      check_val("rst_trap_clr", {63'd0, trap}, 64'd0);
      check_val("rst_cause_clr", {62'd0, trap_cause}, 64'd0);
      RST = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      check_val("rst_imem_req", {63'd0, imem_req}, 64'd0);
      check_val("rst_pc_load", {63'd0, pc_load}, 64'd0);
      check_val("rst_trap", {63'd0, trap}, 64'd0);
      check_val("rst_cause", {62'd0, trap_cause}, 64'd0);
      check_val("rst_cycle_cnt", cycle_cnt, 64'd0);
      RST = 1'b1;

      // ADD
      run_instr(7'b0110011, 0);
      check_val("add_first_req", {63'd0, res_first_req}, 64'd1);
      check_val("add_cycles", res_cycles, 4);
      check_val("add_irl", res_irl, 1);
      check_val("add_pcl", res_pcl, 1);
      check_val("add_mem", res_mem, 0);
      check_val("add_rf", {63'd0, res_rf}, 64'd1);
      check_val("add_wb", {62'd0, res_wb}, 64'd0);
      check_val("add_next", {63'd0, res_next}, 64'd0);
      check_val("add_srcb", {63'd0, res_srcb}, 64'd0);

      // ADDI uses the immediate operand
      run_instr(7'b0010011, 0);
      check_val("addi_cycles", res_cycles, 4);
      check_val("addi_srcb", {63'd0, res_srcb}, 64'd1);

      // LD with three wait cycles
      run_instr(7'b0000011, 3);
      check_val("ld_cycles", res_cycles, 8);
      check_val("ld_mem", res_mem, 4);
      check_val("ld_we", {63'd0, res_we}, 64'd0);
      check_val("ld_wb", {62'd0, res_wb}, 64'd1);
      check_val("ld_rf", {63'd0, res_rf}, 64'd1);

      // SD
      run_instr(7'b0100011, 0);
      check_val("sd_cycles", res_cycles, 5);
      check_val("sd_we", {63'd0, res_we}, 64'd1);
      check_val("sd_rf", {63'd0, res_rf}, 64'd0);
      check_val("sd_pcl", res_pcl, 1);

      // JALR / JAL / branch / LUI / AUIPC
      run_instr(7'b1100111, 0);
      check_val("jalr_next", {63'd0, res_next}, 64'd1);
      check_val("jalr_adder", {63'd0, res_adder}, 64'd0);
      check_val("jalr_wb", {62'd0, res_wb}, 64'd2);
      check_val("jalr_rf", {63'd0, res_rf}, 64'd1);
      run_instr(7'b1101111, 0);
      check_val("jal_next", {63'd0, res_next}, 64'd1);
      check_val("jal_adder", {63'd0, res_adder}, 64'd1);
      check_val("jal_wb", {62'd0, res_wb}, 64'd2);
      run_instr(7'b1100011, 0);
      check_val("br_cycles", res_cycles, 4);
      check_val("br_rf", {63'd0, res_rf}, 64'd0);
      check_val("br_next", {63'd0, res_next}, 64'd0);
      check_val("br_adder", {63'd0, res_adder}, 64'd1);
      run_instr(7'b0110111, 0);
      check_val("lui_wb", {62'd0, res_wb}, 64'd3);
      run_instr(7'b0010111, 0);
      check_val("auipc_wb", {62'd0, res_wb}, 64'd0);
      check_val("auipc_srcb", {63'd0, res_srcb}, 64'd1);

      // Ready on the limit cycle wins
      run_instr(7'b0000011, 4);
      check_val("dlim_trap", {63'd0, res_trap}, 64'd0);
      check_val("dlim_mem", res_mem, 5);
      check_val("dlim_cycles", res_cycles, 9);

      // dmem timeout
      run_instr(7'b0000011, 5);
      check_val("dto_trap", {63'd0, res_trap}, 64'd1);
      check_val("dto_cause", {62'd0, trap_cause}, 64'd3);
      check_val("dto_mem", res_mem, 5);
      check_val("dto_pcl", res_pcl, 0);
      do_reset();

      // Illegal opcode
      run_instr(7'b1111111, 0);
      check_val("ill_trap", {63'd0, res_trap}, 64'd1);
      check_val("ill_cycles", res_cycles, 2);
      check_val("ill_cause", {62'd0, trap_cause}, 64'd1);
      n = 0;
      for (int c = 0; c < 4; c++) begin
         if (imem_req || ir_load || pc_load || rf_we) n++;
         @(posedge CLK);
         #1;
      end
      check_val("ill_quiet", n, 0);
      check_val("ill_sticky", {63'd0, trap}, 64'd1);
      do_reset();
      #1;
      check_val("ill_refetch", {63'd0, imem_req}, 64'd1);
      @(posedge CLK);
      #1;

      // imem timeout
      do_reset();
      imem_ready = 1'b0;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (trap) break;
         if (imem_req) n++;
         @(posedge CLK);
         #1;
      end
      check_val("ito_fetch_cycles", n, 5);
      check_val("ito_trap", {63'd0, trap}, 64'd1);
      check_val("ito_cause", {62'd0, trap_cause}, 64'd2);
      @(posedge CLK);
      #1;
      do_reset();

      // Reset during MEM aborts the load
      opcode     = 7'b0000011;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check_val("rmem_in_mem", {63'd0, dmem_req}, 64'd1);
      RST = 1'b0;
      #1;
      check_val("rmem_req_off", {63'd0, dmem_req}, 64'd0);
      check_val("rmem_pcl_off", {63'd0, pc_load}, 64'd0);
      check_val("rmem_rf_off", {63'd0, rf_we}, 64'd0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      imem_ready = 1'b0;
      #1;
      check_val("rmem_fetch", {63'd0, imem_req}, 64'd1);
      check_val("rmem_no_dreq", {63'd0, dmem_req}, 64'd0);
      @(posedge CLK);
      #1;

      // Performance counters across three ADDs
      do_reset();
      for (int k = 0; k < 3; k++) run_instr(7'b0110011, 0);
`ifdef CTRL_PERF_CNT_EN
      check_val("perf_instret", instret_cnt, 64'd3);
      check_val("perf_cycles", cycle_cnt, 64'd12);
`else
      check_val("perf_instret_off", instret_cnt, 64'd0);
      check_val("perf_cycles_off", cycle_cnt, 64'd0);
`endif
      check_val("perf_add_cycles", res_cycles, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
